exhaustive_vector_sequencer: RTL and testbench

Synthesizable stimulus-and-check stage that sits directly upstream of the and4gate block and also consumes its output. It steps all 2^N_IN input combinations onto the DUT inputs and waits a programmable settle time per vector. It then samples f against the expected AND of the vector, counts mismatches and reports pass/done. It replaces hand-written per-vector test sequences with a clocked, board-runnable checker.

---
 rtl/lab_vec_pkg.sv | 19 +
 rtl/settle_timer.sv | 27 ++
 rtl/exhaustive_vector_sequencer.sv | 143 ++++++++++++++
 tb/tb_exhaustive_vector_sequencer.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/lab_vec_pkg.sv
// Shared types and golden function for the exhaustive vector sequencer.
// Optional first-fail capture is controlled in the top by FIRST_FAIL_CAPTURE_EN.
package lab_vec_pkg;

   typedef enum logic [1:0] {IDLE, APPLY, SAMPLE, DONE} seq_state_t;

   localparam int unsigned N_IN_DEFAULT = 4;

   // Expected and4gate output: AND of the low 'width' bits (width <= 32).
   function automatic logic expected_and(input logic [31:0] vec, input int unsigned width);
      logic r;
      r = 1'b1;
      for (int unsigned i = 0; i < 32; i++) begin
         if (i < width) r = r & vec[i];
      end
      return r;
   endfunction

endpackage

// File: rtl/settle_timer.sv
// Per-vector hold counter: counts 0..SETTLE_CYCLES-1 while not cleared, then flags expiry.
module settle_timer #(
   parameter int unsigned SETTLE_CYCLES = 2
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_clear,
   output logic o_expired
);

   localparam int unsigned CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

   logic [CW-1:0] r_cnt;

   assign o_expired = (r_cnt == CW'(SETTLE_CYCLES - 1));

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_cnt <= '0;
      end else if (i_clear) begin
         r_cnt <= '0;
      end else if (!o_expired) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/exhaustive_vector_sequencer.sv
// Sweeps all 2^N_IN vectors onto an and4gate, checks f against &vec, reports pass/done.
// Define FIRST_FAIL_CAPTURE_EN to add first-failing-vector capture outputs.
module exhaustive_vector_sequencer
   import lab_vec_pkg::*;
#(
   parameter int unsigned N_IN          = N_IN_DEFAULT,
   parameter int unsigned SETTLE_CYCLES = 2
) (
   input  logic            i_clk,
   input  logic            i_rst,
   input  logic            i_start,
   output logic [N_IN-1:0] o_vec,
   input  logic            i_f_in,
   output logic            o_busy,
   output logic            o_done,
   output logic            o_pass,
   output logic [N_IN:0]   o_err_count
`ifdef FIRST_FAIL_CAPTURE_EN
   ,
   output logic [N_IN-1:0] o_first_fail_vec,
   output logic            o_first_fail_valid
`endif
);

   localparam logic [N_IN-1:0] LAST_VEC = '1;

   seq_state_t      r_state, w_state_next;
   logic [N_IN-1:0] r_vec, w_vec_next;
   logic            r_busy, w_busy_next;
   logic            r_done, w_done_next;
   logic            r_pass, w_pass_next;
   logic [N_IN:0]   r_err_count, w_err_next;
   logic [N_IN:0]   w_err_inc;
   logic            w_mismatch;
   logic            w_expired;
   logic            w_clear;
`ifdef FIRST_FAIL_CAPTURE_EN
   logic [N_IN-1:0] r_ff_vec, w_ff_vec_next;
   logic            r_ff_valid, w_ff_valid_next;
`endif

   settle_timer #(
      .SETTLE_CYCLES(SETTLE_CYCLES)
   ) u_settle_timer (
      .i_clk    (i_clk),
      .i_rst    (i_rst),
      .i_clear  (w_clear),
      .o_expired(w_expired)
   );

   // Unknown f_in must count as a mismatch, hence the case inequality.
   assign w_mismatch = (i_f_in !== expected_and(32'(r_vec), N_IN));
   assign w_err_inc  = r_err_count + {{N_IN{1'b0}}, w_mismatch};
   assign w_clear    = (r_state != APPLY);

   always_comb begin
      w_state_next = r_state;
      w_vec_next   = r_vec;
      w_busy_next  = r_busy;
      w_done_next  = r_done;
      w_pass_next  = r_pass;
      w_err_next   = r_err_count;
`ifdef FIRST_FAIL_CAPTURE_EN
      w_ff_vec_next   = r_ff_vec;
      w_ff_valid_next = r_ff_valid;
`endif
      unique case (r_state)
         IDLE, DONE: begin
            if (i_start) begin
               w_state_next = APPLY;
               w_vec_next   = '0;
               w_err_next   = '0;
               w_busy_next  = 1'b1;
               w_done_next  = 1'b0;
               w_pass_next  = 1'b0;
`ifdef FIRST_FAIL_CAPTURE_EN
               w_ff_vec_next   = '0;
               w_ff_valid_next = 1'b0;
`endif
            end
         end
         APPLY: begin
            if (w_expired) w_state_next = SAMPLE;
         end
         SAMPLE: begin
            w_err_next = w_err_inc;
`ifdef FIRST_FAIL_CAPTURE_EN
            if (w_mismatch && !r_ff_valid) begin
               w_ff_vec_next   = r_vec;
               w_ff_valid_next = 1'b1;
            end
`endif
            if (r_vec == LAST_VEC) begin
               w_state_next = DONE;
               w_busy_next  = 1'b0;
               w_done_next  = 1'b1;
               w_pass_next  = (w_err_inc == '0);
            end else begin
               w_state_next = APPLY;
               w_vec_next   = r_vec + 1'b1;
            end
         end
         default: w_state_next = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state     <= IDLE;
         r_vec       <= '0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_pass      <= 1'b0;
         r_err_count <= '0;
`ifdef FIRST_FAIL_CAPTURE_EN
         r_ff_vec    <= '0;
         r_ff_valid  <= 1'b0;
`endif
      end else begin
         r_state     <= w_state_next;
         r_vec       <= w_vec_next;
         r_busy      <= w_busy_next;
         r_done      <= w_done_next;
         r_pass      <= w_pass_next;
         r_err_count <= w_err_next;
`ifdef FIRST_FAIL_CAPTURE_EN
         r_ff_vec    <= w_ff_vec_next;
         r_ff_valid  <= w_ff_valid_next;
`endif
      end
   end

   assign o_vec       = r_vec;
   assign o_busy      = r_busy;
   assign o_done      = r_done;
   assign o_pass      = r_pass;
   assign o_err_count = r_err_count;
`ifdef FIRST_FAIL_CAPTURE_EN
   assign o_first_fail_vec   = r_ff_vec;
   assign o_first_fail_valid = r_ff_valid;
`endif

endmodule

// File: tb/tb_exhaustive_vector_sequencer.sv
// Bench for exhaustive_vector_sequencer with behavioural stand-ins for the and4gate DUT.
// Also checks first-fail outputs when FIRST_FAIL_CAPTURE_EN is defined.
module tb_exhaustive_vector_sequencer;

   localparam int N   = 4;
   localparam int S   = 2;
   localparam int NV  = 1 << N;
   localparam int LAT = NV * (S + 1);

   logic          i_clk = 1'b0;
   logic          i_rst;
   logic          i_start;
   logic [N-1:0]  o_vec;
   logic          i_f_in;
   logic          o_busy;
   logic          o_done;
   logic          o_pass;
   logic [N:0]    o_err_count;
`ifdef FIRST_FAIL_CAPTURE_EN
   logic [N-1:0]  o_first_fail_vec;
   logic          o_first_fail_valid;
`endif

   int            checks = 0;
   int            errors = 0;
   int            mode;
   logic [NV-1:0] flip;

   always #5 i_clk = ~i_clk;

   exhaustive_vector_sequencer #(
      .N_IN         (N),
      .SETTLE_CYCLES(S)
   ) dut (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .i_start    (i_start),
      .o_vec      (o_vec),
      .i_f_in     (i_f_in),
      .o_busy     (o_busy),
      .o_done     (o_done),
      .o_pass     (o_pass),
      .o_err_count(o_err_count)
`ifdef FIRST_FAIL_CAPTURE_EN
      ,
      .o_first_fail_vec  (o_first_fail_vec),
      .o_first_fail_valid(o_first_fail_valid)
`endif
   );

   // Stand-in gate: 0 = correct AND, 1 = stuck at 0, 2 = OR, 3 = AND with random flips.
   function automatic logic gate_f(input int m, input int v, input logic [NV-1:0] fl);
      case (m)
         0:       return v == NV - 1;
         1:       return 1'b0;
         2:       return v != 0;
         default: return (v == NV - 1) ^ fl[v];
      endcase
   endfunction

   always_comb i_f_in = gate_f(mode, int'(o_vec), flip);

   task automatic test_sweep(input string name, input int m, input int inject_at);
      int exp_err, exp_first, lat, bad_steps;
      logic [N-1:0] exp_vec;
      mode      = m;
      exp_err   = 0;
      exp_first = -1;
      for (int v = 0; v < NV; v++) begin
         if (gate_f(m, v, flip) != (v == NV - 1)) begin
            exp_err++;
            if (exp_first < 0) exp_first = v;
         end
      end
      i_start = 1'b1;
      @(posedge i_clk); #1;
      i_start = 1'b0;
      checks++;
      if (o_done !== 1'b0 || o_pass !== 1'b0 || o_err_count !== '0 || o_busy !== 1'b1
          || o_vec !== '0) begin
         errors++;
         $display("FAIL %s start_state: done=%b pass=%b err=%0d busy=%b vec=%h, required 0 0 0 1 0",
                  name, o_done, o_pass, o_err_count, o_busy, o_vec);
      end
      lat       = -1;
      bad_steps = 0;
      for (int n = 1; n <= LAT + 10; n++) begin
         if (n == inject_at) i_start = 1'b1;
         @(posedge i_clk); #1;
         i_start = 1'b0;
         if (o_done === 1'b1) begin
            lat = n;
            break;
         end
         exp_vec = N'(n / (S + 1));
         if (o_vec !== exp_vec || o_busy !== 1'b1) bad_steps++;
      end
      checks++;
      if (lat != LAT) begin
         errors++;
         $display("FAIL %s latency: got %0d cycles, required %0d", name, lat, LAT);
      end
      checks++;
      if (bad_steps != 0) begin
         errors++;
         $display("FAIL %s vec_steps: %0d cycles with wrong vec/busy, required 0", name, bad_steps);
      end
      checks++;
      if (o_err_count !== (N + 1)'(exp_err)) begin
         errors++;
         $display("FAIL %s err_count: got %0d, required %0d", name, o_err_count, exp_err);
      end
      checks++;
      if (o_pass !== (exp_err == 0)) begin
         errors++;
         $display("FAIL %s pass: got %b, required %b", name, o_pass, exp_err == 0);
      end
      checks++;
      if (o_busy !== 1'b0 || o_vec !== {N{1'b1}}) begin
         errors++;
         $display("FAIL %s done_state: busy=%b vec=%h, required 0 and all ones", name, o_busy, o_vec);
      end
`ifdef FIRST_FAIL_CAPTURE_EN
      checks++;
      if (o_first_fail_valid !== (exp_first >= 0)
          || (exp_first >= 0 && o_first_fail_vec !== N'(exp_first))) begin
         errors++;
         $display("FAIL %s first_fail: valid=%b vec=%h, required valid=%b vec=%0d", name,
                  o_first_fail_valid, o_first_fail_vec, exp_first >= 0, exp_first);
      end
`endif
      repeat (3) @(posedge i_clk);
      #1;
      checks++;
      if (o_done !== 1'b1 || o_err_count !== (N + 1)'(exp_err) || o_vec !== {N{1'b1}}) begin
         errors++;
         $display("FAIL %s hold: done=%b err=%0d vec=%h, required 1 %0d all ones", name, o_done,
                  o_err_count, o_vec, exp_err);
      end
   endtask

   task automatic test_reset();
      i_rst   = 1'b1;
      i_start = 1'b0;
      mode    = 0;
      flip    = '0;
      repeat (2) @(posedge i_clk);
      #1;
      i_rst = 1'b0;
      @(posedge i_clk); #1;
      checks++;
      if (o_vec !== '0 || o_busy !== 1'b0 || o_done !== 1'b0 || o_pass !== 1'b0
          || o_err_count !== '0) begin
         errors++;
         $display("FAIL reset_state: vec=%h busy=%b done=%b pass=%b err=%0d, required all 0",
                  o_vec, o_busy, o_done, o_pass, o_err_count);
      end
   endtask

   task automatic test_async_reset();
      mode    = 1;
      i_start = 1'b1;
      @(posedge i_clk); #1;
      i_start = 1'b0;
      repeat (20) @(posedge i_clk);
      #3;
      i_rst = 1'b1;
      #1;
      checks++;
      if (o_vec !== '0 || o_busy !== 1'b0 || o_done !== 1'b0 || o_pass !== 1'b0
          || o_err_count !== '0) begin
         errors++;
         $display("FAIL async_reset: vec=%h busy=%b done=%b pass=%b err=%0d, required all 0",
                  o_vec, o_busy, o_done, o_pass, o_err_count);
      end
      @(posedge i_clk); #1;
      i_rst = 1'b0;
      repeat (2) @(posedge i_clk);
      #1;
      checks++;
      if (o_busy !== 1'b0 || o_done !== 1'b0) begin
         errors++;
         $display("FAIL async_reset_idle: busy=%b done=%b, required 0 0", o_busy, o_done);
      end
      test_sweep("after_reset", 0, -1);
   endtask

   task automatic test_random();
      for (int k = 0; k < 4; k++) begin
         flip = NV'($urandom);
         test_sweep("random", 3, -1);
      end
   endtask

   initial begin
      test_reset();
      test_sweep("and4", 0, -1);
      test_sweep("const0", 1, -1);
      test_sweep("or4", 2, -1);
      test_sweep("start_ignored", 2, 10);
      test_async_reset();
      test_sweep("back_to_back_1", 1, -1);
      test_sweep("back_to_back_2", 1, -1);
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
